// File: rtl/compa16_axil_regs_if.sv
// rtl/compa16_axil_regs_if.sv - AXI4-Lite register bus bundle for the 16-bit comparator block
interface compa16_axil_regs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/compa16_axil_regs.sv
// rtl/compa16_axil_regs.sv - AXI4-Lite register block with pipelined 16-bit comparator
// Optional irq output when COMPA16_IRQ_EN is defined.
module compa16_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    compa16_axil_regs_if.slave s_axi,
    output logic               lt,
    output logic               eq,
    output logic               gt
`ifdef COMPA16_IRQ_EN
    ,
    output logic               irq
`endif
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DW-1:0] opa, opb, ctrl, scratch, rd_mux;
    logic [2:0]    waddr, raddr;
    logic          wr_fire, rd_fire, start_req;
    logic          s1_go, s2_go, sgn_q, cmp_lt, cmp_eq;
    logic [15:0]   a_q, b_q, count;
    logic          res_lt, res_eq, res_gt, done;
    logic          unused_bits;

    assign waddr       = s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign raddr       = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};
    assign s_axi.BRESP = 2'b00;
    assign s_axi.RRESP = 2'b00;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [NB-1:0] strb);
        logic [DW-1:0] res;
        for (int i = 0; i < NB; i++)
            res[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Ready outputs are gated by ARESETN so nothing handshakes while reset is held.
    always_comb begin
        w_next        = w_state;
        s_axi.AWREADY = 1'b0;
        s_axi.WREADY  = 1'b0;
        s_axi.BVALID  = 1'b0;
        case (w_state)
            W_IDLE: if (ARESETN && s_axi.AWVALID && s_axi.WVALID) begin
                s_axi.AWREADY = 1'b1;
                s_axi.WREADY  = 1'b1;
                w_next        = W_RESP;
            end
            W_RESP: begin
                s_axi.BVALID = 1'b1;
                if (s_axi.BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next        = r_state;
        s_axi.ARREADY = 1'b0;
        s_axi.RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi.ARREADY = ARESETN;
                if (ARESETN && s_axi.ARVALID) r_next = R_DATA;
            end
            R_DATA: begin
                s_axi.RVALID = 1'b1;
                if (s_axi.RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign wr_fire   = s_axi.AWREADY;
    assign rd_fire   = s_axi.ARREADY && s_axi.ARVALID;
    assign start_req = wr_fire && (waddr == 3'd2) && s_axi.WSTRB[0] && s_axi.WDATA[0];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            opa     <= '0;
            opb     <= '0;
            ctrl    <= '0;
            scratch <= '0;
        end else if (wr_fire) begin
            case (waddr)
                3'd0:    opa     <= merge(opa, s_axi.WDATA, s_axi.WSTRB);
                3'd1:    opb     <= merge(opb, s_axi.WDATA, s_axi.WSTRB);
                3'd2:    ctrl    <= merge(ctrl, s_axi.WDATA, s_axi.WSTRB);
                3'd3:    scratch <= merge(scratch, s_axi.WDATA, s_axi.WSTRB);
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (raddr)
            3'd0:    rd_mux = opa;
            3'd1:    rd_mux = opb;
            3'd2:    rd_mux = ctrl;
            3'd3:    rd_mux = scratch;
            3'd4:    rd_mux = {count, 12'd0, done, res_gt, res_eq, res_lt};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) s_axi.RDATA <= '0;
        else if (rd_fire) s_axi.RDATA <= rd_mux;
    end

    assign cmp_lt = sgn_q ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
    assign cmp_eq = (a_q == b_q);

    // Stage 1 samples operands the edge after START; a fresh START cancels the in-flight stage 2.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s1_go  <= 1'b0;
            s2_go  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            res_lt <= 1'b0;
            res_eq <= 1'b0;
            res_gt <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
        end else begin
            s1_go <= start_req;
            s2_go <= s1_go && !start_req;
            if (s1_go) begin
                a_q   <= opa[15:0];
                b_q   <= opb[15:0];
                sgn_q <= ctrl[1];
            end
            if (s2_go) begin
                res_lt <= cmp_lt;
                res_eq <= cmp_eq;
                res_gt <= !cmp_lt && !cmp_eq;
                done   <= 1'b1;
                count  <= count + 16'd1;
            end else if (rd_fire && raddr == 3'd4) begin
                done <= 1'b0;
            end
        end
    end

    assign lt = res_lt;
    assign eq = res_eq;
    assign gt = res_gt;

`ifdef COMPA16_IRQ_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) irq <= 1'b0;
        else          irq <= done && ctrl[2];
    end
`endif
endmodule

// File: tb/tb_compa16_axil_regs.sv
// tb/tb_compa16_axil_regs.sv - self-checking bench for compa16_axil_regs
module tb_compa16_axil_regs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lt, eq, gt;
`ifdef COMPA16_IRQ_EN
    logic irq;
`endif
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    compa16_axil_regs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    compa16_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .ACLK(clk), .ARESETN(rst_n), .s_axi(bus), .lt(lt), .eq(eq), .gt(gt)
`ifdef COMPA16_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: register file plus a list of scheduled compare completions.
    typedef struct { int due; logic [2:0] res; } pend_t;
    pend_t       q[$];
    logic [31:0] m_reg [4];
    logic [2:0]  m_res;
    logic        m_done, m_irq, m_widle, m_ridle;
    logic [15:0] m_count;
    logic [31:0] m_rexp;

    function automatic logic [2:0] cmp16(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        int ia, ib;
        ia = a;
        ib = b;
        if (sgn && a[15]) ia = ia - 65536;
        if (sgn && b[15]) ib = ib - 65536;
        if (ia < ib) return 3'b001;
        if (ia == ib) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        if (idx < 3'd4) return m_reg[idx];
        if (idx == 3'd4) return {m_count, 12'd0, m_done, m_res[2], m_res[1], m_res[0]};
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        logic aw_acc, b_hs, ar_acc, r_hs, clr, new_irq;
        logic [2:0] ai;
        if (!rst_n) begin
            chk("reset_handshake", {27'd0, bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID}, 32'd0);
            chk("reset_rdata", bus.RDATA, 32'd0);
            chk("reset_cmp_out", {29'd0, lt, eq, gt}, 32'd0);
`ifdef COMPA16_IRQ_EN
            chk("reset_irq", {31'd0, irq}, 32'd0);
`endif
            for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
            q.delete();
            m_res = 3'd0; m_done = 1'b0; m_irq = 1'b0; m_count = 16'd0;
            m_widle = 1'b1; m_ridle = 1'b1; m_rexp = 32'd0;
        end else begin
            aw_acc = m_widle && bus.AWVALID && bus.WVALID;
            chk("awready_wready", {30'd0, bus.AWREADY, bus.WREADY}, {30'd0, aw_acc, aw_acc});
            chk("bvalid", {31'd0, bus.BVALID}, {31'd0, !m_widle});
            chk("arready", {31'd0, bus.ARREADY}, {31'd0, m_ridle});
            chk("rvalid", {31'd0, bus.RVALID}, {31'd0, !m_ridle});
            chk("resp_okay", {28'd0, bus.BRESP, bus.RRESP}, 32'd0);
            if (!m_ridle) chk("rdata_model", bus.RDATA, m_rexp);
            chk("cmp_out", {29'd0, lt, eq, gt}, {29'd0, m_res[0], m_res[1], m_res[2]});
`ifdef COMPA16_IRQ_EN
            chk("irq_model", {31'd0, irq}, {31'd0, m_irq});
`endif
            b_hs    = !m_widle && bus.BREADY;
            ar_acc  = m_ridle && bus.ARVALID;
            r_hs    = !m_ridle && bus.RREADY;
            new_irq = m_done && m_reg[2][2];
            if (ar_acc) m_rexp = model_read(bus.ARADDR[4:2]);
            clr = ar_acc && bus.ARADDR[4:2] == 3'd4;
            if (aw_acc) begin
                ai = bus.AWADDR[4:2];
                if (ai < 3'd4)
                    for (int b = 0; b < 4; b++)
                        if (bus.WSTRB[b]) m_reg[ai][8*b +: 8] = bus.WDATA[8*b +: 8];
                if (ai == 3'd2 && bus.WSTRB[0] && bus.WDATA[0]) begin
                    q.delete();
                    q.push_back('{cyc + 3, cmp16(m_reg[0][15:0], m_reg[1][15:0], m_reg[2][1])});
                end
            end
            if (q.size() > 0 && q[0].due == cyc + 1) begin
                m_res = q[0].res;
                m_count = m_count + 16'd1;
                m_done = 1'b1;
                void'(q.pop_front());
            end else if (clr) begin
                m_done = 1'b0;
            end
            m_irq = new_irq;
            if (aw_acc) m_widle = 1'b0; else if (b_hs) m_widle = 1'b1;
            if (ar_acc) m_ridle = 1'b0; else if (r_hs) m_ridle = 1'b1;
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int bdelay);
        int n;
        bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = (bdelay == 0);
        n = 0;
        @(negedge clk);
        while (!bus.AWREADY && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("write_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        if (bdelay > 0) begin
            for (int i = 0; i < bdelay; i++) begin
                @(negedge clk);
                chk("bp_bvalid_held", {31'd0, bus.BVALID}, 32'd1);
                chk("bp_aw_w_ready_low", {30'd0, bus.AWREADY, bus.WREADY}, 32'd0);
            end
            @(posedge clk); #1;
            bus.BREADY = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!bus.BVALID && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("bvalid_timeout", 32'd0, 32'd1);
        chk("bresp", {30'd0, bus.BRESP}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [4:0] a, input int rdelay, output logic [31:0] d);
        int n;
        logic [31:0] first;
        bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = (rdelay == 0);
        n = 0;
        @(negedge clk);
        while (!bus.ARREADY && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("read_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        if (rdelay > 0) begin
            first = 32'd0;
            for (int i = 0; i < rdelay; i++) begin
                @(negedge clk);
                if (i == 0) first = bus.RDATA;
                chk("bp_rdata_stable", bus.RDATA, first);
                chk("bp_arready_low", {31'd0, bus.ARREADY}, 32'd0);
            end
            @(posedge clk); #1;
            bus.RREADY = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!bus.RVALID && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("rvalid_timeout", 32'd0, 32'd1);
        d = bus.RDATA;
        chk("rresp", {30'd0, bus.RRESP}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;

    initial begin
        bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b1; bus.ARADDR = '0; bus.ARPROT = '0;
        bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arready_after_reset", {31'd0, bus.ARREADY}, 32'd1);
        settle();

        axi_write(5'h00, 32'h1, 4'hF, 0);
        axi_write(5'h04, 32'h2, 4'hF, 0);
        axi_write(5'h08, 32'h3, 4'hF, 0);
        axi_write(5'h0C, 32'h4, 4'hF, 0);
        axi_read(5'h00, 0, rd); chk("rb_opa", rd, 32'h1);
        axi_read(5'h04, 0, rd); chk("rb_opb", rd, 32'h2);
        axi_read(5'h08, 0, rd); chk("rb_ctrl", rd, 32'h3);
        axi_read(5'h0C, 0, rd); chk("rb_scratch", rd, 32'h4);

        do_reset();
        settle();
        axi_write(5'h00, 32'h0005, 4'hF, 0);
        axi_write(5'h04, 32'h0005, 4'hF, 0);
        axi_write(5'h08, 32'h1, 4'hF, 0);
        chk("eq_before_stage2", {31'd0, eq}, 32'd0);
        settle();
        chk("eq_after_stage2", {31'd0, eq}, 32'd1);
        axi_read(5'h10, 0, rd); chk("result_eq", rd, 32'h0001000A);

        do_reset();
        settle();
        axi_write(5'h00, 32'hFFFF, 4'hF, 0);
        axi_write(5'h04, 32'h0001, 4'hF, 0);
        axi_write(5'h08, 32'h1, 4'hF, 0);
        settle();
        axi_read(5'h10, 0, rd); chk("result_unsigned_gt", rd, 32'h0001000C);
        axi_write(5'h08, 32'h3, 4'hF, 0);
        settle();
        axi_read(5'h10, 0, rd); chk("result_signed_lt", rd, 32'h00020009);
        axi_read(5'h10, 0, rd); chk("result_done_cleared", rd, 32'h00020001);

        fork
            axi_write(5'h08, 32'h1, 4'hF, 0);
            begin
                repeat (2) @(posedge clk);
                #1;
                axi_read(5'h10, 0, rd);
                chk("coincident_read_pre_update", rd, 32'h00020001);
            end
        join
        settle();
        axi_read(5'h10, 0, rd); chk("coincident_done_kept", rd, 32'h0003000C);
        axi_read(5'h10, 0, rd); chk("coincident_then_clear", rd, 32'h00030004);

        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 0);
        axi_read(5'h10, 0, rd); chk("result_ro", rd, 32'h00030004);
        axi_write(5'h14, 32'hDEADBEEF, 4'hF, 0);
        axi_read(5'h14, 0, rd); chk("unmapped_zero", rd, 32'h0);

        axi_write(5'h0C, 32'hA5A5A5A5, 4'hF, 5);
        axi_read(5'h0C, 5, rd); chk("bp_scratch", rd, 32'hA5A5A5A5);
        axi_write(5'h0C, 32'h11223344, 4'b0101, 0);
        axi_read(5'h0C, 0, rd); chk("wstrb_merge", rd, 32'hA522A544);

        axi_write(5'h00, 32'h8000, 4'hF, 0);
        axi_write(5'h04, 32'h7FFF, 4'hF, 0);
        axi_write(5'h08, 32'h3, 4'hF, 0);
        settle();
        axi_read(5'h10, 0, rd); chk("signed_min_lt", rd, 32'h00040009);
        axi_write(5'h08, 32'h1, 4'hF, 0);
        settle();
        axi_read(5'h10, 0, rd); chk("unsigned_min_gt", rd, 32'h0005000C);

        bus.AWADDR = 5'h08; bus.WDATA = 32'h1; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 20 && !bus.AWREADY; n++) @(negedge clk);
        chk("midreset_accept", {31'd0, bus.AWREADY}, 32'd1);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        chk("midreset_bvalid_before", {31'd0, bus.BVALID}, 32'd1);
        rst_n = 1'b0;
        #1 chk("midreset_bvalid_drop", {31'd0, bus.BVALID}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.BREADY = 1'b1;
        repeat (4) settle();
        chk("midreset_no_late_result", {29'd0, lt, eq, gt}, 32'd0);
        axi_read(5'h10, 0, rd); chk("midreset_result_zero", rd, 32'h0);

`ifdef COMPA16_IRQ_EN
        axi_write(5'h08, 32'h5, 4'hF, 0);
        for (int n = 0; n < 10 && !irq; n++) settle();
        chk("irq_set", {31'd0, irq}, 32'd1);
        axi_read(5'h10, 0, rd); chk("irq_result", rd, 32'h0001000A);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/compa16_axil_regs.md
COMPA16_AXIL_REGS -- requirements
Module: compa16_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 word registers).
REQ-003 SHALL have a single clock, ACLK (input, 1), with all logic on its rising edge.
REQ-004 SHALL have ARESETN (input, 1), an asynchronous, active-low reset.
REQ-005 SHALL have the AXI4-Lite write ports AWADDR in 5, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1, WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1, BRESP out 2, BVALID out 1, BREADY in 1.
REQ-006 SHALL have the AXI4-Lite read ports ARADDR in 5, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1, RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1.
REQ-007 SHALL have the comparator outputs lt, eq, gt (out, 1 each), mirroring RESULT[2:0].
REQ-008 SHALL have irq (out, 1) present only when COMPA16_IRQ_EN is defined.

Function
REQ-009 SHALL implement this register map:
- 0x00 OPA, RW, 32 bits stored; compare uses [15:0].
- 0x04 OPB, RW, same as OPA.
- 0x08 CTRL, RW: bit0 START, bit1 SIGNED, bit2 IRQ_EN.
- 0x0C SCRATCH, RW.
- 0x10 RESULT, RO: bit0 LT, bit1 EQ, bit2 GT, bit3 DONE, [31:16] COUNT.
- 0x14-0x1C: reads return 0; writes are ignored.
REQ-010 SHALL return OKAY for every BRESP and RRESP, including unmapped and RO addresses.
REQ-011 SHALL honour WSTRB per byte on RW registers.
REQ-012 SHALL run the write FSM with states W_IDLE and W_RESP:
- In W_IDLE, AWREADY and WREADY assert for one cycle only when AWVALID and WVALID are both high.
- The register is updated on that edge.
- The FSM then enters W_RESP with BVALID=1 on the next cycle.
- BVALID holds until BREADY is seen, then the FSM returns to W_IDLE.
- AWREADY and WREADY stay 0 while in W_RESP.
REQ-013 SHALL run the read FSM with states R_IDLE and R_DATA:
- ARREADY=1 in R_IDLE.
- On ARVALID & ARREADY, RDATA is registered and RVALID=1 on the next cycle.
- RDATA stays stable and RVALID holds until RREADY, then the FSM returns to R_IDLE.
- ARREADY=0 in R_DATA.
REQ-014 SHALL trigger a compare when a CTRL write accepted at edge N has WDATA[0]=1 with WSTRB[0]=1. START is also stored, so it reads back as written.
REQ-015 SHALL run a two-stage compare pipeline:
- Edge N+1 latches OPA[15:0], OPB[15:0] and SIGNED.
- Edge N+2 updates LT/EQ/GT (exactly one set), sets DONE, and increments COUNT.
REQ-016 SHALL compare as two's complement when SIGNED=1 and unsigned otherwise.
REQ-017 SHALL wrap COUNT from 0xFFFF to 0x0000.
REQ-018 SHALL clear DONE on a RESULT read handshake; if DONE is set in the same cycle, set wins.
REQ-019 SHALL restart the pipeline with current operands on a new START while a compare is pending; only completed compares increment COUNT.
REQ-020 SHALL allow write and read FSMs to proceed concurrently. A read of RESULT coincident with stage-2 update returns the pre-update value.

Reset
REQ-021 SHALL, while ARESETN=0, hold:
- all registers, COUNT, DONE, lt/eq/gt and irq at 0;
- AWREADY, WREADY, ARREADY, BVALID and RVALID at 0;
- BRESP, RRESP and RDATA at 0;
- both FSMs in IDLE.
REQ-022 SHALL, on reset assertion mid-transaction or mid-compare, drop BVALID/RVALID immediately and discard the pending compare.
REQ-023 SHALL assert ARREADY=1 on the first cycle after ARESETN deasserts.

Configuration
REQ-024 SHALL compile in, when COMPA16_IRQ_EN is defined, a registered irq = DONE & CTRL.IRQ_EN, updated one cycle after either changes.
REQ-025 SHALL, when COMPA16_IRQ_EN is undefined, omit the irq port; CTRL bit2 remains RW storage with no effect.

Verification
REQ-026 Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back -> 0x1,0x2,0x3,0x4 with OKAY responses.
REQ-027 Unsigned and signed compare:
- OPA=0x0005, OPB=0x0005, CTRL=0x1 -> RESULT=0x0001000A two cycles after write accept; eq=1.
- OPA=0xFFFF, OPB=0x0001, CTRL=0x1 -> RESULT[3:0]=0xC (GT).
- Same operands, CTRL=0x3 -> RESULT[3:0]=0x9 (LT); COUNT=2.
REQ-028 DONE handling:
- Read RESULT -> DONE clears (second read [3:0]=0x1 after an LT result).
- RESULT read coincident with stage-2 update -> DONE stays 1.
REQ-029 Backpressure:
- Hold BREADY=0 for 5 cycles -> BVALID stays 1 and AWREADY/WREADY stay 0.
- Hold RREADY=0 for 5 cycles -> RDATA stable and ARREADY=0.
REQ-030 Pull ARESETN low one cycle after START write accept -> RESULT=0, COUNT=0, BVALID=0 next cycle, and no late DONE.
REQ-031 With COMPA16_IRQ_EN: CTRL=0x5 -> irq=1 one cycle after DONE; RESULT read -> irq=0 one cycle after DONE clears.
